// File: rtl/fc_layer_sequencer.sv
// -----------------------------------------------------------------------------
// fc_layer_sequencer
//   Walks every (output neuron, input) pair of one fully-connected layer in
//   row-major order and presents each pair as a beat to the MAC over a
//   valid/ready handshake. The weight address is built incrementally, so no
//   multiplier is needed. A start/busy/done handshake faces the layer
//   controller.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), synchronous active-low reset
//   start_i            begin a layer (sampled only in IDLE)
//   abort_i            cancel a running layer (no done_o)
//   in_last_i          last input index  (inputs  - 1), latched at start
//   out_last_i         last neuron index (neurons - 1), latched at start
//   weight_base_i      weight address of (neuron 0, input 0), latched at start
//   ready_i            MAC accepts the current beat
//   valid_o            beat valid
//   in_idx_o           current input index
//   out_idx_o          current neuron index
//   weight_addr_o      current weight address
//   first_o            beat is input 0 of a neuron (clear accumulator)
//   last_o             beat is the last input of a neuron (write result)
//   busy_o             high in RUN and DONE
//   done_o             one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module fc_layer_sequencer #(
    parameter int InBits   = 10,
    parameter int OutBits  = 8,
    parameter int AddrBits = 17
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [InBits-1:0]   in_last_i,
    input  logic [OutBits-1:0]  out_last_i,
    input  logic [AddrBits-1:0] weight_base_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [InBits-1:0]   in_idx_o,
    output logic [OutBits-1:0]  out_idx_o,
    output logic [AddrBits-1:0] weight_addr_o,
    output logic                first_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [InBits-1:0]     in_idx_q, in_idx_d;
    logic [OutBits-1:0]    out_idx_q, out_idx_d;
    logic [AddrBits-1:0]   addr_q, addr_d;
    logic [InBits-1:0]     in_last_q, in_last_d;
    logic [OutBits-1:0]    out_last_q, out_last_d;
    logic                  xfer;

    assign valid_o       = (state_q == RUN);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign in_idx_o      = in_idx_q;
    assign out_idx_o     = out_idx_q;
    assign weight_addr_o = addr_q;
    assign first_o       = valid_o && (in_idx_q == '0);
    assign last_o        = valid_o && (in_idx_q == in_last_q);
    assign xfer          = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            in_idx_q   <= '0;
            out_idx_q  <= '0;
            addr_q     <= '0;
            in_last_q  <= '0;
            out_last_q <= '0;
        end else begin
            state_q    <= state_d;
            in_idx_q   <= in_idx_d;
            out_idx_q  <= out_idx_d;
            addr_q     <= addr_d;
            in_last_q  <= in_last_d;
            out_last_q <= out_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_idx_d   = in_idx_q;
        out_idx_d  = out_idx_q;
        addr_d     = addr_q;
        in_last_d  = in_last_q;
        out_last_d = out_last_q;

        case (state_q)
            IDLE: begin
                // abort_i has no meaning here, so start always wins.
                if (start_i) begin
                    state_d    = RUN;
                    in_last_d  = in_last_i;
                    out_last_d = out_last_i;
                    in_idx_d   = '0;
                    out_idx_d  = '0;
                    addr_d     = weight_base_i;
                end
            end
            RUN: begin
                // Abort beats a coincident final-beat transfer: the MAC took
                // the beat, but the layer is not reported as done.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    if (in_idx_q != in_last_q) begin
                        in_idx_d = in_idx_q + InBits'(1);
                        addr_d   = addr_q + AddrBits'(1);
                    end else if (out_idx_q != out_last_q) begin
                        // Row-major weights: next row starts at the next word.
                        in_idx_d  = '0;
                        out_idx_d = out_idx_q + OutBits'(1);
                        addr_d    = addr_q + AddrBits'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
- Sequences one fully-connected MNIST layer: walks every (output neuron, input) pair in row-major order.
- Emits input index, neuron index, weight address and accumulator control flags to the downstream MAC over a valid/ready handshake.
- Takes the place of hand-wired increment-then-stop counter chains around the MAC. Provides a start/busy/done handshake to the top-level layer controller.

Parameters:
- InBits, 10, width of input index (784 inputs max per layer → 10 bits)
- OutBits, 8, width of output-neuron index
- AddrBits, 17, width of weight memory address

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  begin layer; sampled only in IDLE
- abort_i  in  1  synchronous cancel of a running layer
- in_last_i  in  InBits  last input index (number of inputs − 1)
- out_last_i  in  OutBits  last neuron index (number of neurons − 1)
- weight_base_i  in  AddrBits  weight address of (neuron 0, input 0)
- ready_i  in  1  MAC accepts current beat
- valid_o  out  1  beat valid
- in_idx_o  out  InBits  current input index
- out_idx_o  out  OutBits  current neuron index
- weight_addr_o  out  AddrBits  current weight address
- first_o  out  1  beat is input 0 of a neuron (MAC clears accumulator)
- last_o  out  1  beat is input in_last of a neuron (MAC writes result)
- busy_o  out  1  high in RUN and DONE
- done_o  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (rst_ni=0 at a clock edge) has priority over everything. It forces:
  - state=IDLE
  - all outputs 0, all latched config 0
- Reset mid-layer discards progress; no done_o is generated.
- States: IDLE, RUN, DONE.
- IDLE:
  - valid_o=0, busy_o=0.
  - On start_i=1: latch in_last_i, out_last_i, weight_base_i; load in_idx=0, out_idx=0, weight_addr=weight_base_i; go to RUN.
  - valid_o rises the cycle after start_i is sampled (1-cycle latency).
- Config inputs are ignored after the latch. Changing them mid-layer has no effect.
- RUN:
  - valid_o=1, busy_o=1.
  - A beat transfers on a clock edge with valid_o && ready_i.
  - While valid_o && !ready_i, all beat outputs hold stable (no change of idx/addr/flags).
- Advance on transfer:
  - If in_idx != in_last: in_idx+1, weight_addr+1.
  - Else if out_idx != out_last: in_idx=0, out_idx+1, weight_addr+1.
  - Else (final beat): go to DONE, valid_o=0 next cycle.
- Combinational flags:
  - first_o = valid_o && in_idx==0
  - last_o = valid_o && in_idx==in_last
- Degenerate case in_last=0: first_o and last_o are both high on every beat.
- weight_addr always equals weight_base + out_idx*(in_last+1) + in_idx.
  - Generated incrementally, no multiplier.
  - Wraps modulo 2^AddrBits.
- Total beats per layer = (in_last+1)*(out_last+1). Minimum case 0/0 gives exactly 1 beat.
- DONE:
  - done_o=1 for exactly this one cycle, busy_o=1, valid_o=0.
  - Next state is IDLE unconditionally.
  - start_i asserted during DONE is ignored, so back-to-back layers need start_i in IDLE.
- start_i in RUN/DONE: ignored, no restart.
- abort_i in RUN: next state IDLE, valid_o=0 next cycle, no done_o.
  - abort_i wins over a simultaneous final-beat transfer; that beat counts as accepted by the MAC but done_o is suppressed.
- abort_i in IDLE/DONE: no effect.
- start_i and abort_i together in IDLE: start wins (abort has no effect in IDLE).
- ready_i is ignored when valid_o=0.

Test Plan:
- Reset mid-run:
  - Stimulus: start with in_last=3, out_last=1, base=0x100; ready_i=1; pull rst_ni low at beat 5.
  - Required: next cycle all outputs 0, IDLE; no done_o.
- Small layer, full throughput:
  - Stimulus: in_last=3, out_last=2, base=0x040, ready_i=1.
  - Required: 12 consecutive beats with addr 0x040..0x04B and (out,in) = (0,0),(0,1)..(2,3).
  - Required flags: first_o on in=0, last_o on in=3.
  - Required: done_o exactly 1 cycle after beat 12; busy_o high from the cycle after start through done.
- Backpressure:
  - Stimulus: same layer, ready_i toggling 1,0,0,1…
  - Required: outputs frozen while ready_i=0; same 12-beat sequence; done_o after the last accepted beat only.
- Degenerate and wrap:
  - Stimulus A: in_last=0, out_last=0. Required: one beat with first_o=last_o=1, then done_o.
  - Stimulus B: base=0x1FFFE, in_last=3, out_last=0. Required: addresses 1FFFE, 1FFFF, 00000, 00001.
- Abort:
  - Stimulus: abort_i on beat 7 of a 12-beat layer, and separately on the final beat with ready_i=1.
  - Required: both return to IDLE with no done_o.
  - Then start_i with new config: sequence restarts at in=0, out=0, new base.
- Ignored start and config change:
  - Stimulus: pulse start_i in RUN and in DONE; change in_last_i mid-run.
  - Required: beat count and addresses unchanged; a single done_o.
